multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. Sequences each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. In DECODE it latches the instruction fields and classifies the opcode into `alu_op`. It feeds `alu_op`, `fn3`, `fn7_5`, `imm11_5` and `ex_en` directly into `alu_control`, and drives the memory and register-file strobes, the PC advance and the retired-instruction count.

## Interface
- `TIMEOUT`, 16: consecutive not-ready cycles tolerated in FETCH or MEMORY before trapping; must be ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction word from instruction memory; sampled when `imem_ready`=1 in FETCH.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory access complete.
- `fetch_en`, `dec_en`, `ex_en`, `mem_en`, `wb_en` out 1 each: stage enables; at most one high.
- `alu_op` out 3: instruction class.
  - 000 R, 001 I/LUI/AUIPC, 010 load, 011 store, 100 branch, 101 JAL/JALR.
- `fn3` out 3: latched `instr[14:12]`; forced to 000 for LUI, AUIPC and JAL.
- `fn7_5` out 1: latched `instr[30]`, R-type only; otherwise 0.
- `imm11_5` out 7: latched `instr[31:25]`.
- `mem_rd`, `mem_wr` out 1: data memory read/write strobes.
- `reg_wr` out 1: register-file write enable.
- `pc_en` out 1: one-cycle pulse that advances the PC and retires the instruction.
- `instret` out 32: count of retired instructions; wraps.
- `illegal` out 1: sticky; set on an unknown opcode.
- `timeout_err` out 1: sticky; set on a ready timeout.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- Outputs are Moore, decoded from the state and the latched class; none are combinational from inputs, except `pc_en` in MEMORY.
- **FETCH**
  - Drives `fetch_en`=1.
  - `imem_ready`=1: latch `instr[6:0]`, fields and class registers → DECODE.
- **DECODE**
  - Drives `dec_en`=1 and classifies the latched opcode:
    - 0110011 → 000
    - 0010011, 0110111, 0010111 → 001
    - 0000011 → 010
    - 0100011 → 011
    - 1100011 → 100
    - 1101111, 1100111 → 101
  - Any other opcode → TRAP, and sets `illegal`.
  - Otherwise → EXECUTE.
- **EXECUTE**
  - Drives `ex_en`=1 for exactly one cycle.
  - Load/store → MEMORY.
  - Branch: `pc_en`=1 → FETCH.
  - All others → WRITEBACK.
- **MEMORY**
  - Drives `mem_en`=1, plus `mem_rd`=1 for a load or `mem_wr`=1 for a store; the strobe is held until `dmem_ready`.
  - On `dmem_ready`=1: load → WRITEBACK; store → FETCH, with `pc_en`=1 in that same cycle.
- **WRITEBACK**
  - Drives `wb_en`=1, `reg_wr`=1, `pc_en`=1 → FETCH.
  - x0 is not filtered here; the register file ignores writes to x0.
- **TRAP**
  - All enables and strobes are 0.
  - Field outputs hold their last values.
  - Exit only via `rst`.
- **Wait counter**
  - Increments each cycle in FETCH or MEMORY while the relevant ready is 0; clears on every state change.
  - If ready=0 and the count equals `TIMEOUT`-1 → TRAP, and sets `timeout_err`.
- `instret` increments on every cycle with `pc_en`=1.

## Timing
- **Reset:** on `rst` assertion, asynchronously:
  - state = FETCH;
  - `alu_op`, `fn3`, `fn7_5`, `imm11_5`, `instret`, wait counter, `illegal`, `timeout_err` all = 0.
  - In the first cycle after deassertion: `fetch_en`=1 and all other enables and strobes = 0.
- **Cycles per instruction**, with zero-wait memories (FETCH counted as 1):
  - R/I/JAL: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Each ready wait adds 1 cycle.
- Fields latched at the FETCH→DECODE edge are stable through the end of the instruction; `alu_control` therefore sees a stable `alu_op` and `fn3` throughout `ex_en`.
- **Ready priority:** if ready=1 in the same cycle the counter reaches `TIMEOUT`-1, ready wins and there is no trap.
- **Reset mid-instruction:** the instruction is abandoned and not counted; no strobe is issued after assertion.
- **`instret` wrap:** 0xFFFFFFFF → 0x00000000, with no flag.

## Test plan
- **Reset then ADD:** reset, then `instr`=0x002081B3 with `imem_ready`=1.
  - Required: F, D, E, W over 4 cycles.
  - `alu_op`=000, `fn3`=000, `fn7_5`=0.
  - `reg_wr` and `pc_en` high only in cycle 4; `instret`=1.
- **SUB / SRAI decode:**
  - SUB 0x402081B3 → `fn7_5`=1, `alu_op`=000.
  - SRAI 0x4030D193 → `alu_op`=001, `fn3`=101, `imm11_5`=0x20.
- **LW with 3-cycle `dmem_ready` delay:**
  - Required: MEMORY lasts 4 cycles with `mem_rd`=1 throughout.
  - Then WRITEBACK; total 8 cycles.
- **Store and branch:**
  - SW 0x0020A023: `pc_en` in the MEMORY cycle, `reg_wr` never asserted.
  - BEQ 0x00208463: 3 cycles, `alu_op`=100, `pc_en` in EXECUTE.
- **Illegal opcode:** `instr`=0x0000007F.
  - Required: TRAP after DECODE; `illegal`=1 and held; no enables for 20 cycles.
  - `rst` clears `illegal`.
- **Timeout:** `imem_ready`=0 held with `TIMEOUT`=16.
  - Required: TRAP entered after 16 FETCH cycles; `timeout_err`=1.
  - Repeat with `imem_ready`=1 in the 16th cycle: required DECODE, no trap.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP)
// with instruction-field latching, ready-timeout trapping and a retired-instruction counter.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        fetch_en,
   output logic        dec_en,
   output logic        ex_en,
   output logic        mem_en,
   output logic        wb_en,
   output logic [2:0]  alu_op,
   output logic [2:0]  fn3,
   output logic        fn7_5,
   output logic [6:0]  imm11_5,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic        reg_wr,
   output logic        pc_en,
   output logic [31:0] instret,
   output logic        illegal,
   output logic        timeout_err
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] C_R      = 3'b000;
   localparam logic [2:0] C_I      = 3'b001;
   localparam logic [2:0] C_LOAD   = 3'b010;
   localparam logic [2:0] C_STORE  = 3'b011;
   localparam logic [2:0] C_BRANCH = 3'b100;
   localparam logic [2:0] C_JUMP   = 3'b101;

   logic [2:0]    state;
   logic [2:0]    state_n;
   logic [CW-1:0] wait_cnt;
   logic          legal;
   logic          cnt_inc;
   logic          latch;
   logic          ill_set;
   logic          tmo_set;
   logic [2:0]    cls_c;
   logic          legal_c;
   logic          at_limit;

   // Register-file address bits are decoded elsewhere in the core
   logic unused_bits;
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   assign at_limit = (wait_cnt == CW'(TIMEOUT - 1));

   // Opcode classification of the incoming instruction word
   always_comb begin
      cls_c   = C_R;
      legal_c = 1'b1;
      case (instr[6:0])
         OP_R:                     cls_c = C_R;
         OP_I, OP_LUI, OP_AUIPC:   cls_c = C_I;
         OP_LOAD:                  cls_c = C_LOAD;
         OP_STORE:                 cls_c = C_STORE;
         OP_BRANCH:                cls_c = C_BRANCH;
         OP_JAL, OP_JALR:          cls_c = C_JUMP;
         default:                  legal_c = 1'b0;
      endcase
   end

   // Next-state logic, wait-counter control and sticky-flag set requests
   always_comb begin
      state_n = state;
      cnt_inc = 1'b0;
      latch   = 1'b0;
      ill_set = 1'b0;
      tmo_set = 1'b0;
      case (state)
         S_FETCH: begin
            if (imem_ready) begin
               latch   = 1'b1;
               state_n = S_DECODE;
            end else if (at_limit) begin
               tmo_set = 1'b1;
               state_n = S_TRAP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_DECODE: begin
            if (!legal) begin
               ill_set = 1'b1;
               state_n = S_TRAP;
            end else begin
               state_n = S_EXEC;
            end
         end
         S_EXEC: begin
            if (alu_op == C_LOAD || alu_op == C_STORE) state_n = S_MEM;
            else if (alu_op == C_BRANCH)               state_n = S_FETCH;
            else                                       state_n = S_WB;
         end
         S_MEM: begin
            if (dmem_ready) begin
               state_n = (alu_op == C_LOAD) ? S_WB : S_FETCH;
            end else if (at_limit) begin
               tmo_set = 1'b1;
               state_n = S_TRAP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_WB:    state_n = S_FETCH;
         S_TRAP:  state_n = S_TRAP;
         default: state_n = S_FETCH;
      endcase
   end

   // Moore stage enables and strobes; only the store retire pulse looks at dmem_ready
   always_comb begin
      fetch_en = (state == S_FETCH);
      dec_en   = (state == S_DECODE);
      ex_en    = (state == S_EXEC);
      mem_en   = (state == S_MEM);
      wb_en    = (state == S_WB);
      mem_rd   = (state == S_MEM) && (alu_op == C_LOAD);
      mem_wr   = (state == S_MEM) && (alu_op == C_STORE);
      reg_wr   = (state == S_WB);
      pc_en    = ((state == S_EXEC) && (alu_op == C_BRANCH)) ||
                 ((state == S_MEM) && (alu_op == C_STORE) && dmem_ready) ||
                 (state == S_WB);
   end

   // State register and wait counter; the counter restarts on every state change
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_n;
         if (state_n != state) wait_cnt <= '0;
         else if (cnt_inc)     wait_cnt <= wait_cnt + CW'(1);
      end
   end

   // Instruction fields and class, captured when the fetch completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_op  <= 3'b000;
         fn3     <= 3'b000;
         fn7_5   <= 1'b0;
         imm11_5 <= 7'b0;
         legal   <= 1'b0;
      end else if (latch) begin
         alu_op  <= cls_c;
         legal   <= legal_c;
         imm11_5 <= instr[31:25];
         fn7_5   <= (instr[6:0] == OP_R) ? instr[30] : 1'b0;
         fn3     <= (instr[6:0] == OP_LUI || instr[6:0] == OP_AUIPC || instr[6:0] == OP_JAL)
                    ? 3'b000 : instr[14:12];
      end
   end

   // Retired-instruction counter and sticky error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret     <= 32'd0;
         illegal     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (pc_en)   instret     <= instret + 32'd1;
         if (ill_set) illegal     <= 1'b1;
         if (tmo_set) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output schedule from the cycle-count rules; a compare process checks every cycle.
module tb_multicycle_ctrl;

   localparam int unsigned T = 16;

   localparam logic [4:0] EN_F = 5'b10000;
   localparam logic [4:0] EN_D = 5'b01000;
   localparam logic [4:0] EN_E = 5'b00100;
   localparam logic [4:0] EN_M = 5'b00010;
   localparam logic [4:0] EN_W = 5'b00001;
   localparam logic [4:0] EN_0 = 5'b00000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'd0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        fetch_en, dec_en, ex_en, mem_en, wb_en;
   logic [2:0]  alu_op, fn3;
   logic        fn7_5;
   logic [6:0]  imm11_5;
   logic        mem_rd, mem_wr, reg_wr, pc_en;
   logic [31:0] instret;
   logic        illegal, timeout_err;

   multicycle_ctrl #(.TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .fetch_en(fetch_en), .dec_en(dec_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
      .alu_op(alu_op), .fn3(fn3), .fn7_5(fn7_5), .imm11_5(imm11_5),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr), .pc_en(pc_en),
      .instret(instret), .illegal(illegal), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Expected values for the current cycle
   bit          exp_valid = 1'b0;
   bit          fields_ok = 1'b1;
   logic [4:0]  e_en;
   logic        e_rd, e_wr, e_rw, e_pc;
   logic [31:0] e_ret;
   // Model state
   logic [31:0] m_ret = 32'd0;
   logic [2:0]  m_alu = 3'd0, m_fn3 = 3'd0;
   logic        m_f7 = 1'b0, m_ill = 1'b0, m_tmo = 1'b0;
   logic [6:0]  m_imm = 7'd0;
   // Updates that become visible one cycle after they are scheduled
   bit          pend_f = 1'b0, pend_ill = 1'b0, pend_tmo = 1'b0;
   logic [2:0]  p_alu, p_fn3;
   logic        p_f7;
   logic [6:0]  p_imm;
   bit          trapped = 1'b0;

   logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   // {legal, class} from the opcode table
   function automatic logic [3:0] cls_of(input logic [6:0] op);
      case (op)
         7'h33:               return 4'b1000;
         7'h13, 7'h37, 7'h17: return 4'b1001;
         7'h03:               return 4'b1010;
         7'h23:               return 4'b1011;
         7'h63:               return 4'b1100;
         7'h6F, 7'h67:        return 4'b1101;
         default:             return 4'b0000;
      endcase
   endfunction

   // Compare DUT against the expected schedule every cycle
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (exp_valid) begin
            chk("ctrl", {fetch_en, dec_en, ex_en, mem_en, wb_en, mem_rd, mem_wr, reg_wr, pc_en,
                         illegal, timeout_err},
                        {e_en, e_rd, e_wr, e_rw, e_pc, m_ill, m_tmo});
            chk("instret", instret, e_ret);
            if (fields_ok)
               chk("fields", {alu_op, fn3, fn7_5, imm11_5}, {m_alu, m_fn3, m_f7, m_imm});
         end
      end
   end

   // One clock cycle: drive inputs and publish what the outputs must be
   task automatic cyc(input logic [4:0] en, input logic rd, input logic wr, input logic rw,
                      input logic pc, input logic ir, input logic dr, input logic [31:0] iw);
      @(negedge clk);
      rst = 1'b0;
      if (pend_f) begin
         m_alu = p_alu; m_fn3 = p_fn3; m_f7 = p_f7; m_imm = p_imm; pend_f = 1'b0;
      end
      if (pend_ill) begin m_ill = 1'b1; pend_ill = 1'b0; end
      if (pend_tmo) begin m_tmo = 1'b1; pend_tmo = 1'b0; end
      imem_ready = ir;
      dmem_ready = dr;
      instr      = iw;
      e_en = en; e_rd = rd; e_wr = wr; e_rw = rw; e_pc = pc;
      e_ret = m_ret;
      if (pc) m_ret = m_ret + 32'd1;
      exp_valid = 1'b1;
   endtask

   task automatic set_pend(input logic [31:0] iw);
      logic [3:0] c;
      c = cls_of(iw[6:0]);
      p_alu = c[2:0];
      p_fn3 = (iw[6:0] == 7'h37 || iw[6:0] == 7'h17 || iw[6:0] == 7'h6F) ? 3'd0 : iw[14:12];
      p_f7  = (iw[6:0] == 7'h33) ? iw[30] : 1'b0;
      p_imm = iw[31:25];
      pend_f = 1'b1;
      if (!c[3]) fields_ok = 1'b0;
   endtask

   task automatic trap_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(EN_0, 1'b0, 1'b0, 1'b0, 1'b0, rb(), rb(), $urandom);
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      exp_valid = 1'b0;
      #3;
      chk("rst_ctrl", {fetch_en, dec_en, ex_en, mem_en, wb_en, mem_rd, mem_wr, reg_wr, pc_en,
                       illegal, timeout_err}, {EN_F, 6'b0});
      chk("rst_state", {instret, alu_op, fn3, fn7_5, imm11_5}, 46'd0);
      m_ret = 32'd0; m_alu = 3'd0; m_fn3 = 3'd0; m_f7 = 1'b0; m_imm = 7'd0;
      m_ill = 1'b0; m_tmo = 1'b0;
      pend_f = 1'b0; pend_ill = 1'b0; pend_tmo = 1'b0;
      fields_ok = 1'b1;
      trapped = 1'b0;
   endtask

   // Expected schedule of one instruction with wf fetch waits and wm memory waits
   task automatic run_instr(input logic [31:0] iw, input int wf, input int wm);
      logic [3:0] c;
      logic       is_ld, is_st, is_br;
      c = cls_of(iw[6:0]);
      is_ld = c[3] && (c[2:0] == 3'd2);
      is_st = c[3] && (c[2:0] == 3'd3);
      is_br = c[3] && (c[2:0] == 3'd4);
      for (int i = 0; i < wf && i < int'(T); i++)
         cyc(EN_F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rb(), $urandom);
      if (wf >= int'(T)) begin pend_tmo = 1'b1; trapped = 1'b1; return; end
      cyc(EN_F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rb(), iw);
      set_pend(iw);
      cyc(EN_D, 1'b0, 1'b0, 1'b0, 1'b0, rb(), rb(), $urandom);
      if (!c[3]) begin pend_ill = 1'b1; trapped = 1'b1; return; end
      cyc(EN_E, 1'b0, 1'b0, 1'b0, is_br, rb(), rb(), $urandom);
      if (is_ld || is_st) begin
         for (int i = 0; i < wm && i < int'(T); i++)
            cyc(EN_M, is_ld, is_st, 1'b0, 1'b0, rb(), 1'b0, $urandom);
         if (wm >= int'(T)) begin pend_tmo = 1'b1; trapped = 1'b1; return; end
         cyc(EN_M, is_ld, is_st, 1'b0, is_st, rb(), 1'b1, $urandom);
      end
      if (!is_br && !is_st) cyc(EN_W, 1'b0, 1'b0, 1'b1, 1'b1, rb(), rb(), $urandom);
   endtask

   task automatic pin_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] iw;
      int          r, wf, wm;

      do_reset();

      // Reset then ADD x3,x1,x2
      run_instr(32'h002081B3, 0, 0);
      pin_edge();
      chk("add_instret", instret, 32'd1);
      chk("add_fields", {alu_op, fn3, fn7_5}, 7'd0);
      chk("add_next_fetch", {fetch_en, dec_en, ex_en, mem_en, wb_en}, EN_F);

      // SUB and SRAI decode
      run_instr(32'h402081B3, 0, 0);
      pin_edge();
      chk("sub_fields", {alu_op, fn7_5}, 4'b0001);
      run_instr(32'h4030D193, 0, 0);
      pin_edge();
      chk("srai_fields", {alu_op, fn3, fn7_5, imm11_5}, {3'd1, 3'd5, 1'b0, 7'h20});

      // LW with three not-ready memory cycles
      run_instr(32'h0000A183, 0, 3);
      pin_edge();
      chk("lw_instret", instret, 32'd4);

      // SW and BEQ
      run_instr(32'h0020A023, 0, 0);
      run_instr(32'h00208463, 0, 0);
      pin_edge();
      chk("beq_fields", {alu_op, instret}, {3'd4, 32'd6});

      // Ready in the last tolerated cycle wins over the timeout
      run_instr(32'h002081B3, int'(T) - 1, 0);
      pin_edge();
      chk("ready_wins", {timeout_err, instret}, {1'b0, 32'd7});

      // Fetch timeout
      run_instr(32'h002081B3, int'(T), 0);
      trap_cycles(3);
      pin_edge();
      chk("fetch_timeout", {timeout_err, illegal, fetch_en}, 3'b100);
      do_reset();

      // Illegal opcode holds in TRAP until reset
      run_instr(32'h0000007F, 0, 0);
      trap_cycles(20);
      pin_edge();
      chk("illegal_trap", {illegal, fetch_en, dec_en, ex_en, mem_en, wb_en, pc_en}, 7'b1000000);
      do_reset();

      // Reset in the middle of a load's memory wait
      run_instr(32'h002081B3, 0, 0);
      cyc(EN_F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rb(), 32'h0000A183);
      set_pend(32'h0000A183);
      cyc(EN_D, 1'b0, 1'b0, 1'b0, 1'b0, rb(), rb(), $urandom);
      cyc(EN_E, 1'b0, 1'b0, 1'b0, 1'b0, rb(), rb(), $urandom);
      cyc(EN_M, 1'b1, 1'b0, 1'b0, 1'b0, rb(), 1'b0, $urandom);
      do_reset();

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         r  = $urandom_range(0, 99);
         iw = $urandom;
         iw[6:0] = ops[$urandom_range(0, 8)];
         wf = (r < 60) ? 0 : (r < 90) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 15));
         r  = $urandom_range(0, 99);
         wm = (r < 60) ? 0 : (r < 90) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 15));
         if (r == 97) iw[6:0] = 7'h7F;
         if (r == 98) wf = int'(T);
         if (r == 99) wm = int'(T);
         run_instr(iw, wf, wm);
         if (trapped) begin
            trap_cycles(int'($urandom_range(1, 6)));
            do_reset();
         end
      end

      @(negedge clk);
      exp_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
